// File: rtl/mpc_h_vector_reader_pkg.sv
// Shared definitions for the h-vector memory readers.
package mpc_h_pkg;

  localparam int H_ADDR_W = 5;
  localparam int H_DATA_W = 21;
  localparam int H_CNT_W  = 6;

  typedef logic signed [H_DATA_W-1:0] h_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  localparam h_word_t H_BOUND_DEFAULT = 21'd163840;

endpackage

// File: rtl/mpc_h_vector_reader_if.sv
// Control, RAM read port and output stream of the h-vector reader.
interface mpc_h_vector_reader_if
  import mpc_h_pkg::*;
#(
  parameter int ADDR_W = H_ADDR_W,
  parameter int DATA_W = H_DATA_W,
  parameter int CNT_W  = H_CNT_W
);
  logic              ap_start;
  logic              ap_done;
  logic              ap_idle;
  logic              ap_ready;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] h_address0;
  logic              h_ce0;
  logic [DATA_W-1:0] h_q0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  ap_start, base, count, h_q0, out_ready,
    output ap_done, ap_idle, ap_ready, h_address0, h_ce0, out_data, out_valid
  );

  modport master (
    output ap_start, base, count, h_q0, out_ready,
    input  ap_done, ap_idle, ap_ready, h_address0, h_ce0, out_data, out_valid
  );
endinterface

// File: rtl/mpc_h_vector_reader_fifo.sv
// Two-entry FIFO used to absorb the one-cycle RAM latency under backpressure.
module mpc_skid_fifo2 #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);
  logic [1:0][W-1:0] mem;
  logic              wr_ptr, rd_ptr;
  logic [1:0]        cnt_q;
  logic              do_push, do_pop;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop && (cnt_q != 2'd0);
  assign do_push = push && ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign count = cnt_q;
endmodule

// File: rtl/mpc_h_vector_reader.sv
// Streams a window of the h RAM out as a valid/ready stream under ap_* block control.
module mpc_h_vector_reader
  import mpc_h_pkg::*;
#(
  parameter int ADDR_W = H_ADDR_W,
  parameter int DATA_W = H_DATA_W,
  parameter int CNT_W  = H_CNT_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  mpc_h_vector_reader_if.slave  bus
);
  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_r;
  logic [CNT_W-1:0]  rem_r;
  logic              inflight_r;

  logic              issue, pop, last_issue;
  logic              fifo_full, fifo_empty;
  logic [1:0]        fifo_cnt;
  logic [2:0]        occ;
  logic [DATA_W-1:0] head;

  assign pop = !fifo_empty && bus.out_ready;
  assign occ = {1'b0, fifo_cnt} + {2'b00, inflight_r};

  // The element leaving this cycle frees a slot, so it counts as credit for a new read.
  assign issue = (state_q == READ) && (rem_r != '0)
              && (occ < (3'd2 + {2'b00, pop}))
              && !(fifo_full && !pop);
  assign last_issue = issue && (rem_r == CNT_W'(1));

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.ap_start) state_d = (bus.count == '0) ? DONE : READ;
      READ:  if (last_issue) state_d = DRAIN;
      DRAIN: if (!inflight_r && (fifo_empty || (fifo_cnt == 2'd1 && pop))) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.h_ce0      = issue;
    bus.h_address0 = addr_r;
    bus.ap_idle    = (state_q == IDLE);
    bus.ap_done    = (state_q == DONE);
    bus.ap_ready   = (state_q == DONE);
    bus.out_valid  = !fifo_empty;
    bus.out_data   = head;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      addr_r     <= '0;
      rem_r      <= '0;
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= issue;
      if (state_q == IDLE && bus.ap_start) begin
        addr_r <= bus.base;
        rem_r  <= bus.count;
      end else if (issue) begin
        addr_r <= addr_r + ADDR_W'(1);
        rem_r  <= rem_r - CNT_W'(1);
      end
    end
  end

  mpc_skid_fifo2 #(.W(DATA_W)) u_fifo (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .push  (inflight_r),
    .pop   (pop),
    .din   (bus.h_q0),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );
endmodule

// File: tb/tb_mpc_h_vector_reader.sv
// Scoreboard bench for mpc_h_vector_reader with a behavioural RAM and stream model.
module tb_mpc_h_vector_reader;
  import mpc_h_pkg::*;

  logic ap_clk = 1'b0;
  logic ap_rst;
  always #5 ap_clk = ~ap_clk;

  mpc_h_vector_reader_if bus();

  mpc_h_vector_reader dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  h_word_t ram [32];
  initial bus.h_q0 = '0;
  always @(posedge ap_clk) if (bus.h_ce0) bus.h_q0 <= ram[bus.h_address0];

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  int n_checks = 0, n_errors = 0;
  h_word_t exp_q[$];
  int start_cyc, job_base, iss_left, iss_idx, outstanding;
  int done_seen, done_rel, first_valid_rel;
  bit hs, stall_prev;
  logic [20:0] prev_data;

  function automatic void chk(input string name, input bit ok, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: compares every emitted element and issued read against the model.
  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      hs = bus.out_valid && bus.out_ready;
      if (bus.h_ce0) begin
        chk("issue_window", (outstanding - int'(hs)) < 2, outstanding - int'(hs), 1);
        if (iss_left == 0) chk("extra_issue", 1'b0, bus.h_address0, -1);
        else begin
          chk("address", bus.h_address0 == 5'((job_base + iss_idx) % 32),
              bus.h_address0, (job_base + iss_idx) % 32);
          iss_idx++;
          iss_left--;
        end
        outstanding++;
      end
      if (stall_prev) begin
        chk("stall_valid", bus.out_valid == 1'b1, bus.out_valid, 1);
        chk("stall_data", bus.out_data == prev_data, bus.out_data, prev_data);
      end
      if (hs) begin
        if (exp_q.size() == 0) chk("unexpected_out", 1'b0, bus.out_data, -1);
        else begin
          h_word_t e;
          e = exp_q.pop_front();
          chk("out_data", bus.out_data == e, bus.out_data, e);
        end
        outstanding--;
      end
      if (bus.out_valid && first_valid_rel < 0) first_valid_rel = cyc - start_cyc;
      if (bus.ap_done || bus.ap_ready) begin
        chk("done_ready_pair", bus.ap_done == bus.ap_ready, bus.ap_ready, bus.ap_done);
        done_seen++;
        done_rel = cyc - start_cyc;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic setup_model(input int b, input int n);
    job_base = b; iss_left = n; iss_idx = 0;
    done_seen = 0; done_rel = -1; first_valid_rel = -1;
    for (int i = 0; i < n; i++) exp_q.push_back(ram[(b + i) % 32]);
  endtask

  // Called just after a rising edge; returns just after the edge that leaves DONE.
  task automatic run_job(input int b, input int n, input bit rnd, input int restart_at);
    int t;
    setup_model(b, n);
    bus.base = 5'(b); bus.count = 6'(n); bus.ap_start = 1'b1;
    bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    start_cyc = cyc;
    t = 0;
    do begin
      @(posedge ap_clk); #1; t++;
      bus.ap_start = ((cyc - start_cyc) == restart_at);
      if (bus.ap_start) begin bus.base = 5'd10; bus.count = 6'd5; end
      else begin bus.base = 5'($urandom); bus.count = 6'($urandom); end
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end while (done_seen == 0 && t < 500);
    bus.ap_start = 1'b0;
    chk("done_timeout", done_seen != 0, t, 500);
    chk("done_once", done_seen == 1, done_seen, 1);
    chk("all_emitted", exp_q.size() == 0, exp_q.size(), 0);
    chk("all_issued", iss_left == 0, iss_left, 0);
    chk("idle_after", bus.ap_idle == 1'b1, bus.ap_idle, 1);
    if (!rnd) begin
      chk("done_cycle", done_rel == ((n == 0) ? 1 : n + 3), done_rel, (n == 0) ? 1 : n + 3);
      if (n > 0) chk("first_valid_cycle", first_valid_rel == 3, first_valid_rel, 3);
      else       chk("no_valid", first_valid_rel < 0, first_valid_rel, -1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_idle"}, bus.ap_idle == 1'b1, bus.ap_idle, 1);
    chk({tag, "_done"}, bus.ap_done == 1'b0, bus.ap_done, 0);
    chk({tag, "_ready"}, bus.ap_ready == 1'b0, bus.ap_ready, 0);
    chk({tag, "_ce0"}, bus.h_ce0 == 1'b0, bus.h_ce0, 0);
    chk({tag, "_valid"}, bus.out_valid == 1'b0, bus.out_valid, 0);
    chk({tag, "_addr"}, bus.h_address0 == '0, bus.h_address0, 0);
    chk({tag, "_data"}, bus.out_data == '0, bus.out_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 32; a++)
      ram[a] = (a >= 4 && a <= 6) ? H_BOUND_DEFAULT : h_word_t'(a);
    outstanding = 0; iss_left = 0; iss_idx = 0; job_base = 0; start_cyc = 0;
    done_seen = 0; done_rel = -1; first_valid_rel = -1;
    ap_rst = 1'b1;
    bus.ap_start = 1'b0; bus.base = '0; bus.count = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    check_reset_outputs("reset");
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;

    run_job(4, 3, 1'b0, -1);
    run_job(30, 4, 1'b0, -1);
    run_job(0, 8, 1'b1, -1);
    run_job(0, 0, 1'b0, -1);

    run_job(0, 8, 1'b0, 2);
    repeat (12) @(posedge ap_clk);
    #1;
    chk("restart_ignored", done_seen == 1, done_seen, 1);

    // Abort a running job with reset at cycle 4.
    setup_model(0, 8);
    bus.base = 5'd0; bus.count = 6'd8; bus.ap_start = 1'b1; bus.out_ready = 1'b1;
    start_cyc = cyc;
    @(posedge ap_clk); #1;
    bus.ap_start = 1'b0;
    while ((cyc - start_cyc) < 4) begin @(posedge ap_clk); #1; end
    ap_rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    exp_q.delete(); iss_left = 0; outstanding = 0;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    @(posedge ap_clk); #1;
    chk("abort_no_done", done_seen == 0, done_seen, 0);
    chk("abort_idle", bus.ap_idle == 1'b1, bus.ap_idle, 1);
    run_job(0, 8, 1'b0, -1);

    for (int k = 0; k < 6; k++)
      run_job(int'($urandom_range(0, 31)), int'($urandom_range(0, 12)),
              1'($urandom_range(0, 1)), -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
